// File: rtl/rv32i_fetch_if.sv
// Fetch-stage bus bundle: instruction ROM port, consumer handshake, redirect input and fault flag.
interface rv32i_fetch_if #(
  parameter int unsigned IMEM_ADDR_W = 10
);
  logic                   imem_en;
  logic [IMEM_ADDR_W-1:0] imem_addr;
  logic [31:0]            imem_rdata;
  logic [31:0]            instr;
  logic [31:0]            instr_pc;
  logic                   instr_valid;
  logic                   instr_ready;
  logic                   redirect_valid;
  logic [31:0]            redirect_pc;
  logic                   fetch_fault;

  modport master (
    output imem_en, imem_addr, instr, instr_pc, instr_valid, fetch_fault,
    input  imem_rdata, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_en, imem_addr, instr, instr_pc, instr_valid, fetch_fault,
    output imem_rdata, instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/rv32i_fetch.sv
// RV32I instruction fetch: PC register, 1-cycle synchronous ROM read, 2-entry
// instruction queue with consumer stall, PC redirect and sticky misalignment fault.
module rv32i_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned IMEM_ADDR_W = 10,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic           clk,
  input  logic           reset,
  rv32i_fetch_if.master  bus
);

  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tag_q, tag_d;
  logic [1:0]  count_q, count_d;
  logic        inflight_q, inflight_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        head_valid, pop, push, issue, out_valid;
  entry_t      fifo_q [2];
  entry_t      head;

  // State and control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      tag_q      <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  // Queue storage holds payload only; occupancy lives in count_q
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_q] <= entry_t'{pc: tag_q, data: bus.imem_rdata};
  end

  // Next-state: redirect beats issue/return; issue keeps queue + in-flight within 2
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tag_d      = tag_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    pop        = 1'b0;
    push       = 1'b0;
    issue      = 1'b0;
    head_valid = (state_q == RUN) && (count_q != 2'd0);
    head       = fifo_q[rd_q];

    unique case (state_q)
      RUN: begin
        if (bus.redirect_valid) begin
          count_d    = '0;
          inflight_d = 1'b0;
          rd_d       = 1'b0;
          wr_d       = 1'b0;
          if (bus.redirect_pc[1:0] != 2'b00) state_d = FAULT;
          else                               pc_d    = bus.redirect_pc;
        end else begin
          pop        = head_valid & bus.instr_ready;
          push       = inflight_q;
          issue      = (3'(count_q) + 3'(inflight_q)) < (3'd2 + 3'(pop));
          inflight_d = issue;
          if (issue) begin
            tag_d = pc_q;
            pc_d  = pc_q + 32'd4;
          end
          count_d = count_q + 2'(push) - 2'(pop);
          rd_d    = rd_q ^ pop;
          wr_d    = wr_q ^ push;
        end
      end
      FAULT: begin
        count_d    = '0;
        inflight_d = 1'b0;
      end
    endcase
  end

  assign out_valid       = head_valid & ~reset;
  assign bus.imem_en     = issue & ~reset;
  assign bus.imem_addr   = pc_q[IMEM_ADDR_W+1:2];
  assign bus.instr_valid = out_valid;
  assign bus.instr       = out_valid ? head.data : NOP_INSTR;
  assign bus.instr_pc    = out_valid ? head.pc : 32'h0000_0000;
  assign bus.fetch_fault = (state_q == FAULT);

endmodule

// File: tb/tb_rv32i_fetch.sv
// Scoreboard bench for rv32i_fetch: driver queues the expected PC/instruction stream,
// a negedge monitor pops and compares on every accepted handshake.
module tb_rv32i_fetch;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] RPC2 = 32'hFFFF_FFF8;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  exp_t exp_q[$];
  logic [31:0] tail_pc;

  rv32i_fetch_if #(.IMEM_ADDR_W(10)) bus ();
  rv32i_fetch_if #(.IMEM_ADDR_W(10)) bus2 ();

  rv32i_fetch #(.RESET_PC(32'h0000_0000), .IMEM_ADDR_W(10), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  rv32i_fetch #(.RESET_PC(RPC2), .IMEM_ADDR_W(10), .NOP_INSTR(NOP)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [9:0] widx);
    return 32'h1000_0000 + {22'd0, widx};
  endfunction

  always @(posedge clk) if (bus.imem_en)  bus.imem_rdata  <= rom_word(bus.imem_addr);
  always @(posedge clk) if (bus2.imem_en) bus2.imem_rdata <= rom_word(bus2.imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream: sequential PCs from the last restart point, data = base + word index
  task automatic topup();
    while (exp_q.size() < 32) begin
      exp_q.push_back('{pc: tail_pc, data: rom_word(tail_pc[11:2])});
      tail_pc = tail_pc + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] start);
    exp_q.delete();
    tail_pc = start;
    topup();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    topup();
  endtask

  // Monitor: handshakes are ignored by the DUT during reset or redirect cycles
  always @(negedge clk) begin
    if (!reset && !bus.redirect_valid) begin
      if (bus.instr_valid) begin
        if (bus.instr_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_underflow: actual pc=%h expected none", bus.instr_pc);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_instr_pc", bus.instr_pc, e.pc);
            check("sb_instr", bus.instr, e.data);
          end
        end
      end else begin
        check("idle_instr", bus.instr, NOP);
        check("idle_pc", bus.instr_pc, 32'h0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tgt;
    int r;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.instr_ready     = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus2.instr_ready    = 1'b1;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = 32'h0;
    restart(32'h0);

    // Reset-cycle outputs
    @(negedge clk);
    check("rst_valid", 32'(bus.instr_valid), 32'h0);
    check("rst_instr", bus.instr, NOP);
    check("rst_pc", bus.instr_pc, 32'h0);
    check("rst_en", 32'(bus.imem_en), 32'h0);
    check("rst_fault", 32'(bus.fetch_fault), 32'h0);

    // First instruction latency, plus RESET_PC wrap on the second instance
    @(posedge clk); #1;
    reset = 1'b0;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check("c0_valid", 32'(bus.instr_valid), 32'h0);
    check("c0_en", 32'(bus.imem_en), 32'h1);
    @(negedge clk);
    check("c1_valid", 32'(bus.instr_valid), 32'h0);
    @(negedge clk);
    check("c2_valid", 32'(bus.instr_valid), 32'h1);
    check("wrap_pc0", bus2.instr_pc, 32'hFFFF_FFF8);
    check("wrap_d0", bus2.instr, 32'h1000_03FE);
    @(negedge clk);
    check("wrap_pc1", bus2.instr_pc, 32'hFFFF_FFFC);
    check("wrap_d1", bus2.instr, 32'h1000_03FF);
    @(negedge clk);
    check("wrap_pc2", bus2.instr_pc, 32'h0000_0000);
    check("wrap_d2", bus2.instr, 32'h1000_0000);
    repeat (6) tick();

    // Stall: hold ready low 5 cycles from reset release
    reset = 1'b1;
    bus.instr_ready = 1'b0;
    restart(32'h0);
    tick();
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("stall_en", 32'(bus.imem_en), 32'h0);
    check("stall_valid", 32'(bus.instr_valid), 32'h1);
    check("stall_pc", bus.instr_pc, 32'h0);
    check("stall_instr", bus.instr, 32'h1000_0000);
    tick();
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("release_valid", 32'(bus.instr_valid), 32'h1);
    end

    // Redirect to 0x40 with the queue full
    tick();
    bus.instr_ready = 1'b0;
    repeat (3) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    restart(32'h40);
    tick();
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b1;
    @(negedge clk);
    check("redir_gap0", 32'(bus.instr_valid), 32'h0);
    @(negedge clk);
    check("redir_gap1", 32'(bus.instr_valid), 32'h0);
    @(negedge clk);
    check("redir_valid", 32'(bus.instr_valid), 32'h1);
    check("redir_pc", bus.instr_pc, 32'h40);
    check("redir_instr", bus.instr, 32'h1000_0010);
    repeat (4) tick();

    // Back-to-back redirects with a fetch in flight: the last one wins
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    restart(32'h100);
    tick();
    bus.redirect_pc    = 32'h200;
    restart(32'h200);
    tick();
    bus.redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    check("b2b_pc", bus.instr_pc, 32'h200);
    repeat (3) tick();

    // Misaligned redirect -> sticky fault; aligned redirect afterwards ignored
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h42;
    restart(32'h0);
    tick();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("fault_set", 32'(bus.fetch_fault), 32'h1);
    check("fault_valid", 32'(bus.instr_valid), 32'h0);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h80;
    tick();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("fault_hold_valid", 32'(bus.instr_valid), 32'h0);
      check("fault_hold_en", 32'(bus.imem_en), 32'h0);
      check("fault_hold", 32'(bus.fetch_fault), 32'h1);
    end

    // Reset concurrent with redirect: reset wins, fault cleared
    tick();
    reset = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h84;
    restart(32'h0);
    tick();
    reset = 1'b0;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("rr_fault", 32'(bus.fetch_fault), 32'h0);
    check("rr_en", 32'(bus.imem_en), 32'h1);
    check("rr_addr", 32'(bus.imem_addr), 32'h0);
    repeat (2) @(negedge clk);
    check("rr_pc", bus.instr_pc, 32'h0);

    // Random ready, aligned redirects and occasional resets
    for (int i = 0; i < 800; i++) begin
      tick();
      reset = 1'b0;
      bus.redirect_valid = 1'b0;
      r = $urandom_range(0, 99);
      bus.instr_ready = ($urandom_range(0, 9) < 7);
      tgt = $urandom() & 32'hFFFF_FFFC;
      if (r < 2) begin
        reset = 1'b1;
        bus.redirect_valid = 1'($urandom_range(0, 1));
        bus.redirect_pc    = tgt;
        restart(32'h0);
      end else if (r < 8) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = tgt;
        restart(tgt);
      end
    end
    tick();
    reset = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.instr_ready = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
